// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Time-multiplexed hex driver for a DIGITS-wide 7-segment
//                display with per-digit decimal points, blanking, leading
//                zero suppression, an anti-ghosting guard interval at the
//                start of every digit slot and frame-synchronous updates.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [4*DIGITS-1:0]                            data,
  input  logic [DIGITS-1:0]                              dp,
  input  logic [DIGITS-1:0]                              blank,
  input  logic                                           lz_suppress,
  input  logic                                           load,
  output logic [6:0]                                     seg,
  output logic                                           seg_dp,
  output logic [DIGITS-1:0]                              an,
  output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] digit_idx,
  output logic                                           frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CW-1:0]     c_cnt_last = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0]     c_idx_last = IW'(DIGITS - 1);
  localparam logic [6:0]        c_seg_off  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              c_dp_off   = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] c_an_off   = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  // Slot phase: GUARD keeps every anode off so the previous digit's
  // segments cannot ghost onto the next anode; DRIVE lights the digit.
  typedef enum logic [0:0] {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // Glyph table in active-low {a..g} form (0 = segment lit).
  function automatic logic [6:0] glyph_al(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    return g;
  endfunction

  // Scan position
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  state_t            state_q, state_d;
  logic              in_guard_d;
  logic              frame_end;

  // Shadow (written by load) and display (used for scanning) copies
  logic [4*DIGITS-1:0] sh_data_q, sh_data_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic                sh_lz_q, sh_lz_d;
  logic                pend_q, pend_d;
  logic [4*DIGITS-1:0] disp_data_q, disp_data_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]   disp_blank_q, disp_blank_d;
  logic                disp_lz_q, disp_lz_d;
  logic                disp_valid_q, disp_valid_d;

  // Digit selection helpers
  logic [DIGITS-1:0] lz_dark;
  logic              zero_run;
  logic [3:0]        sel_nib;
  logic              sel_dp;
  logic              sel_dark;
  logic [DIGITS-1:0] onehot;

  // Registered outputs
  logic [6:0]        seg_q, seg_d;
  logic              seg_dp_q, seg_dp_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              frame_done_q, frame_done_d;

  // Slot counter and digit index advance; the index moves on slot wrap.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (cnt_q == c_cnt_last) begin
      cnt_d = '0;
      idx_d = (idx_q == c_idx_last) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign frame_end = (cnt_q == c_cnt_last) && (idx_q == c_idx_last);

  // Guard window detection; with no guard cycles the digit drives all slot long.
  generate
    if (BLANK_CYCLES > 0) begin : g_guard
      localparam logic [CW-1:0] c_blank = CW'(BLANK_CYCLES);
      assign in_guard_d = (cnt_d < c_blank);
    end else begin : g_no_guard
      assign in_guard_d = 1'b0;
    end
  endgenerate

  // Shadow capture on load; display only changes at the frame boundary,
  // with a load on that very cycle bypassing the shadow.
  always_comb begin
    sh_data_d    = sh_data_q;
    sh_dp_d      = sh_dp_q;
    sh_blank_d   = sh_blank_q;
    sh_lz_d      = sh_lz_q;
    pend_d       = pend_q;
    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    disp_lz_d    = disp_lz_q;
    disp_valid_d = disp_valid_q;
    if (load) begin
      sh_data_d  = data;
      sh_dp_d    = dp;
      sh_blank_d = blank;
      sh_lz_d    = lz_suppress;
      pend_d     = 1'b1;
    end
    if (frame_end) begin
      if (load) begin
        disp_data_d  = data;
        disp_dp_d    = dp;
        disp_blank_d = blank;
        disp_lz_d    = lz_suppress;
        disp_valid_d = 1'b1;
        pend_d       = 1'b0;
      end else if (pend_q) begin
        disp_data_d  = sh_data_q;
        disp_dp_d    = sh_dp_q;
        disp_blank_d = sh_blank_q;
        disp_lz_d    = sh_lz_q;
        disp_valid_d = 1'b1;
        pend_d       = 1'b0;
      end
    end
  end

  // Leading-zero mask: a digit above 0 goes dark when it and every digit above it is zero.
  always_comb begin
    lz_dark  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run   = zero_run & (disp_data_d[4*i +: 4] == 4'h0);
      lz_dark[i] = disp_lz_d & zero_run;
    end
  end

  // Pick the nibble, decimal point and dark flag of the digit entering its slot.
  always_comb begin
    sel_nib  = 4'h0;
    sel_dp   = 1'b0;
    sel_dark = 1'b1;
    onehot   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        sel_nib   = disp_data_d[4*i +: 4];
        sel_dp    = disp_dp_d[i];
        sel_dark  = ~disp_valid_d | disp_blank_d[i] | lz_dark[i];
        onehot[i] = 1'b1;
      end
    end
  end

  // Next-state phase and output values, all derived from next scan position
  // so the registered outputs line up with the counter they describe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_GUARD: if (!in_guard_d) state_d = ST_DRIVE;
      ST_DRIVE: if (in_guard_d)  state_d = ST_GUARD;
      default:  state_d = ST_GUARD;
    endcase

    an_d     = c_an_off;
    seg_d    = c_seg_off;
    seg_dp_d = c_dp_off;
    if (state_d == ST_DRIVE) begin
      an_d = AN_ACTIVE_LOW ? ~onehot : onehot;
      if (!sel_dark) begin
        seg_d    = SEG_ACTIVE_LOW ? glyph_al(sel_nib) : ~glyph_al(sel_nib);
        seg_dp_d = SEG_ACTIVE_LOW ? ~sel_dp : sel_dp;
      end
    end
    frame_done_d = (cnt_d == c_cnt_last) && (idx_d == c_idx_last);
  end

  // Scan FSM, buffers and registered outputs; reset darkens the display at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      state_q      <= ST_GUARD;
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '0;
      sh_lz_q      <= 1'b0;
      pend_q       <= 1'b0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      disp_lz_q    <= 1'b0;
      disp_valid_q <= 1'b0;
      seg_q        <= c_seg_off;
      seg_dp_q     <= c_dp_off;
      an_q         <= c_an_off;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      sh_data_q    <= sh_data_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      sh_lz_q      <= sh_lz_d;
      pend_q       <= pend_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      disp_lz_q    <= disp_lz_d;
      disp_valid_q <= disp_valid_d;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign seg_dp     = seg_dp_q;
  assign an         = an_q;
  assign digit_idx  = idx_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Self-checking bench for seg7_scan_driver. Two instances
//                (active-low and active-high polarities) share stimulus and
//                are compared every cycle against a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 8;
  localparam int BLANK   = 2;
  localparam int FRAME   = DIGITS * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic        lz = 1'b0;
  logic        load = 1'b0;

  logic [6:0] seg_lo, seg_hi;
  logic       dp_lo, dp_hi;
  logic [3:0] an_lo, an_hi;
  logic [1:0] idx_lo, idx_hi;
  logic       fd_lo, fd_hi;

  seg7_scan_driver #(
    .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .data(data), .dp(dp), .blank(blank),
    .lz_suppress(lz), .load(load), .seg(seg_lo), .seg_dp(dp_lo),
    .an(an_lo), .digit_idx(idx_lo), .frame_done(fd_lo)
  );

  seg7_scan_driver #(
    .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK),
    .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) dut_hi (
    .clk(clk), .reset(reset), .data(data), .dp(dp), .blank(blank),
    .lz_suppress(lz), .load(load), .seg(seg_hi), .seg_dp(dp_hi),
    .an(an_hi), .digit_idx(idx_hi), .frame_done(fd_hi)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz;
  } load_t;

  load_t      loads[$];
  logic [6:0] glyph_al [16];
  int         t;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
  endtask

  // Frame-level model: the frame starting at edge F shows the newest load
  // sampled at an edge <= F; within a frame the slot/offset follow from t.
  task automatic model(input int tt, input bit act_low,
                       output logic [3:0] e_an, output logic [6:0] e_seg,
                       output logic e_dp, output logic [1:0] e_idx, output logic e_fd);
    int    off, slot, fstart;
    bit    found, dark;
    load_t cur;
    logic [3:0] oh, nib;
    logic [6:0] lit_seg;
    logic       lit_dp;
    off    = tt % CLK_DIV;
    slot   = (tt / CLK_DIV) % DIGITS;
    fstart = tt - (tt % FRAME);
    found  = 1'b0;
    cur    = '{0, 16'h0, 4'h0, 4'h0, 1'b0};
    foreach (loads[k]) begin
      if (loads[k].t <= fstart) begin
        cur   = loads[k];
        found = 1'b1;
      end
    end
    oh      = (off >= BLANK) ? 4'(1 << slot) : 4'b0;
    nib     = 4'((cur.data >> (4 * slot)) & 16'hF);
    dark    = !found || cur.blank[slot] || (cur.lz && slot > 0 && (cur.data >> (4 * slot)) == 0);
    lit_seg = (oh != 0 && !dark) ? ~glyph_al[nib] : 7'h00;
    lit_dp  = (oh != 0) && !dark && cur.dp[slot];
    e_an    = act_low ? ~oh : oh;
    e_seg   = act_low ? ~lit_seg : lit_seg;
    e_dp    = act_low ? ~lit_dp : lit_dp;
    e_idx   = 2'(slot);
    e_fd    = (slot == DIGITS - 1) && (off == CLK_DIV - 1);
  endtask

  task automatic check_outputs();
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed, ef;
    logic [1:0] ei;
    model(t, 1'b1, ea, es, ed, ei, ef);
    chk("lo_an", an_lo, ea);
    chk("lo_seg", seg_lo, es);
    chk("lo_dp", dp_lo, ed);
    chk("lo_idx", idx_lo, ei);
    chk("lo_frame_done", fd_lo, ef);
    model(t, 1'b0, ea, es, ed, ei, ef);
    chk("hi_an", an_hi, ea);
    chk("hi_seg", seg_hi, es);
    chk("hi_dp", dp_hi, ed);
    chk("hi_idx", idx_hi, ei);
    chk("hi_frame_done", fd_hi, ef);
  endtask

  // One clock: record a pending load at the edge that samples it, then check.
  task automatic tick();
    if (load) loads.push_back('{t + 1, data, dp, blank, lz});
    @(posedge clk);
    #1;
    t++;
    check_outputs();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p,
                         input logic [3:0] b, input logic l);
    data  = d;
    dp    = p;
    blank = b;
    lz    = l;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    while (t % FRAME != ph) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  logic [6:0] t2_seg [4];

  initial begin
    glyph_al = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    t2_seg   = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
    t = 0;

    // Power-up reset, then dark display for three frames without any load
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    t = 0;
    loads.delete();
    check_outputs();
    repeat (3 * FRAME) tick();

    // 1234 shown digit by digit from the next frame on
    do_load(16'h1234, 4'h0, 4'h0, 1'b0);
    wait_phase(0);
    for (int k = 0; k < FRAME; k++) begin
      if (k % CLK_DIV >= BLANK) begin
        chk("t2_seg", seg_lo, t2_seg[k / CLK_DIV]);
        chk("t2_an", an_lo, 4'(~(4'b0001 << (k / CLK_DIV))));
      end else begin
        chk("t2_guard_an", an_lo, 4'b1111);
      end
      tick();
    end

    // Reset mid-slot darkens everything without a clock edge
    wait_phase(4);
    reset = 1'b1;
    #1;
    chk("rst_an", an_lo, 4'b1111);
    chk("rst_seg", seg_lo, 7'h7F);
    chk("rst_dp", dp_lo, 1'b1);
    chk("rst_idx", idx_lo, 2'd0);
    chk("rst_fd", fd_lo, 1'b0);
    chk("rst_hi_an", an_hi, 4'b0000);
    chk("rst_hi_seg", seg_hi, 7'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    t = 0;
    loads.delete();
    check_outputs();
    repeat (FRAME) tick();

    // Leading-zero suppression
    do_load(16'h00A0, 4'h0, 4'h0, 1'b1);
    repeat (2 * FRAME) tick();
    do_load(16'h0000, 4'h0, 4'h0, 1'b1);
    repeat (2 * FRAME) tick();

    // Mid-frame load, then last-wins within one frame
    wait_phase(10);
    do_load(16'hFFFF, 4'h0, 4'h0, 1'b0);
    repeat (2 * FRAME) tick();
    wait_phase(5);
    do_load(16'hAAAA, 4'h0, 4'h0, 1'b0);
    wait_phase(20);
    do_load(16'hBBBB, 4'h0, 4'h0, 1'b0);
    repeat (2 * FRAME) tick();

    // Load on the frame_done cycle reaches the very next digit-0 drive
    wait_phase(FRAME - 1);
    chk("t5_fd", fd_lo, 1'b1);
    do_load(16'h5678, 4'h0, 4'h0, 1'b0);
    tick();
    tick();
    chk("t5_dig0", seg_lo, 7'b0000000);
    repeat (FRAME) tick();

    // Decimal point and blanking, checked on the active-high instance
    do_load(16'h8888, 4'b0010, 4'b0001, 1'b0);
    wait_phase(0);
    wait_phase(CLK_DIV + BLANK);
    chk("t6_d1_seg", seg_hi, 7'h7F);
    chk("t6_d1_dp", dp_hi, 1'b1);
    chk("t6_d1_an", an_hi, 4'b0010);
    wait_phase(BLANK);
    chk("t6_d0_an", an_hi, 4'b0001);
    chk("t6_d0_seg", seg_hi, 7'h00);
    chk("t6_d0_dp", dp_hi, 1'b0);

    // Randomized loads at arbitrary phases
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(15) == 0) begin
        do_load(16'($urandom), 4'($urandom), 4'($urandom_range(15) < 4 ? $urandom : 0),
                1'($urandom));
      end else begin
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
